// File: rtl/password_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : password_ctrl
// Description : Control FSM for a 3-digit hex password lock: set, enter,
//               match, failure counting, freeze and success windows.
// Revision    : 1.0 - initial release
// ============================================================================
module password_ctrl #(
    parameter int unsigned FREEZE_CYCLES  = 500_000_000,
    parameter int unsigned SUCCESS_CYCLES = 300_000_000,
    parameter int unsigned ACK_CYCLES     = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [1:0]  failure_times,
    output logic        success_input,
    output logic [11:0] password_input,
    output logic [2:0]  input_count,
    output logic [2:0]  current_work_state
);

    localparam logic [2:0]  c_IDLE     = 3'b000;
    localparam logic [2:0]  c_SETING   = 3'b001;
    localparam logic [2:0]  c_SETFIN   = 3'b010;
    localparam logic [2:0]  c_INPUTING = 3'b011;
    localparam logic [2:0]  c_SUCCESS  = 3'b100;
    localparam logic [2:0]  c_FREEZED  = 3'b101;

    // Timers count down to zero; the state exits on the cycle the timer reads 0.
    localparam logic [31:0] c_SUCCESS_LOAD = 32'(SUCCESS_CYCLES - 1);
    localparam logic [31:0] c_FREEZE_LOAD  = 32'(FREEZE_CYCLES - 1);
    localparam logic [31:0] c_ACK_LOAD     = 32'(ACK_CYCLES - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_fail;
    logic [11:0] r_buf;
    logic [2:0]  r_cnt;
    logic        r_ack;
    logic [11:0] r_stored;
    logic        r_has_pw;
    logic [31:0] r_win_timer;
    logic [31:0] r_ack_timer;

    logic        w_key_digit;
    logic        w_key_a;
    logic        w_key_b;
    logic        w_key_c;
    logic        w_key_d;
    logic        w_cnt_full;
    logic        w_digit_ok;
    logic        w_bksp_ok;
    logic        w_accept;
    logic [11:0] w_buf_digit;
    logic [11:0] w_buf_bksp;

    assign w_key_digit = key_valid && (key_code <= 4'd9);
    assign w_key_a     = key_valid && (key_code == 4'hA);
    assign w_key_b     = key_valid && (key_code == 4'hB);
    assign w_key_c     = key_valid && (key_code == 4'hC);
    assign w_key_d     = key_valid && (key_code == 4'hD);
    assign w_cnt_full  = (r_cnt == 3'd3);
    assign w_digit_ok  = w_key_digit && !w_cnt_full;
    assign w_bksp_ok   = w_key_c && (r_cnt != 3'd0);

    always_comb begin
        w_buf_digit = r_buf;
        w_buf_bksp  = r_buf;
        case (r_cnt)
            3'd0: w_buf_digit[11:8] = key_code;
            3'd1: begin
                w_buf_digit[7:4] = key_code;
                w_buf_bksp[11:8] = 4'h0;
            end
            3'd2: begin
                w_buf_digit[3:0] = key_code;
                w_buf_bksp[7:4]  = 4'h0;
            end
            3'd3: w_buf_bksp[3:0] = 4'h0;
            default: ;
        endcase
    end

    // A key is accepted when it changes state, buffer or count.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            c_IDLE:     w_accept = w_key_a || (w_key_b && r_has_pw);
            c_SETING,
            c_INPUTING: w_accept = w_digit_ok || w_bksp_ok || w_key_d || (w_key_b && w_cnt_full);
            c_SETFIN:   w_accept = w_key_a || w_key_b || w_key_d;
            default:    w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack       <= 1'b0;
            r_ack_timer <= 32'd0;
        end else if (w_accept) begin
            r_ack       <= 1'b1;
            r_ack_timer <= c_ACK_LOAD;
        end else if (r_ack_timer != 32'd0) begin
            r_ack_timer <= r_ack_timer - 32'd1;
        end else begin
            r_ack       <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_fail      <= 2'd0;
            r_buf       <= 12'h000;
            r_cnt       <= 3'd0;
            r_stored    <= 12'h000;
            r_has_pw    <= 1'b0;
            r_win_timer <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_key_a || (w_key_b && r_has_pw)) begin
                        r_buf   <= 12'h000;
                        r_cnt   <= 3'd0;
                        r_state <= w_key_a ? c_SETING : c_INPUTING;
                    end
                end
                c_SETING, c_INPUTING: begin
                    if (w_key_b) begin
                        if (w_cnt_full && (r_state == c_SETING)) begin
                            r_stored <= r_buf;
                            r_has_pw <= 1'b1;
                            r_state  <= c_SETFIN;
                        end else if (w_cnt_full && (r_buf == r_stored)) begin
                            r_fail      <= 2'd0;
                            r_state     <= c_SUCCESS;
                            r_win_timer <= c_SUCCESS_LOAD;
                        end else if (w_cnt_full) begin
                            r_buf <= 12'h000;
                            r_cnt <= 3'd0;
                            if (r_fail >= 2'd2) begin
                                r_fail      <= 2'd3;
                                r_state     <= c_FREEZED;
                                r_win_timer <= c_FREEZE_LOAD;
                            end else begin
                                r_fail <= r_fail + 2'd1;
                            end
                        end
                    end else if (w_key_d) begin
                        r_buf   <= 12'h000;
                        r_cnt   <= 3'd0;
                        r_state <= c_IDLE;
                    end else if (w_digit_ok) begin
                        r_buf <= w_buf_digit;
                        r_cnt <= r_cnt + 3'd1;
                    end else if (w_bksp_ok) begin
                        r_buf <= w_buf_bksp;
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_SETFIN: begin
                    if (w_key_a || w_key_b || w_key_d) begin
                        r_buf   <= 12'h000;
                        r_cnt   <= 3'd0;
                        r_state <= w_key_a ? c_SETING : (w_key_b ? c_INPUTING : c_IDLE);
                    end
                end
                c_SUCCESS, c_FREEZED: begin
                    if (r_win_timer == 32'd0) begin
                        if (r_state == c_FREEZED) begin
                            r_fail <= 2'd0;
                        end
                        r_buf   <= 12'h000;
                        r_cnt   <= 3'd0;
                        r_state <= c_IDLE;
                    end else begin
                        r_win_timer <= r_win_timer - 32'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign failure_times      = r_fail;
    assign success_input      = r_ack;
    assign password_input     = r_buf;
    assign input_count        = r_cnt;
    assign current_work_state = r_state;

endmodule
`default_nettype wire
